gray_count_checker: RTL and testbench

Receive-side decoder and sequence checker for the Gray-coded counter in the power-analysis designs. Samples a W-bit Gray word every valid cycle, converts it back to binary through a 2-stage pipeline, and verifies that each decoded value is exactly the previous value plus one, modulo 2^W. Reports a per-sample step error, a lock indication, and a saturating error count. Sits downstream of the counter in gate-level and power benches, and doubles as the reference consumer in those designs.

---
 rtl/gray_pkg.sv | 41 ++++
 rtl/gray2bin_w.sv | 14 +
 rtl/gray_count_checker.sv | 128 ++++++++++++
 tb/tb_gray_count_checker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and Gray/binary conversion helpers for the Gray sequence checker
package gray_pkg;

    // Widest word the conversion helpers handle; callers pass their real width.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Ones in the low w bits; keeps stray upper bits out of the decode.
    function automatic logic [MAX_W-1:0] width_mask(input int w);
        if (w >= MAX_W) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

    // Prefix XOR from the MSB down: b[w-1] = g[w-1], b[i] = b[i+1] ^ g[i].
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gw, input int w);
        logic [MAX_W-1:0] gm;
        logic [MAX_W-1:0] b;
        logic             acc;
        gm  = gw & width_mask(w);
        acc = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            acc  = acc ^ gm[i];
            b[i] = acc;
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bw, input int w);
        logic [MAX_W-1:0] bm;
        bm = bw & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

endpackage

// File: rtl/gray2bin_w.sv
// rtl/gray2bin_w.sv - combinational W-bit Gray to binary decoder
module gray2bin_w
    import gray_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] g,
    output logic [W-1:0] b
);

    // Purely combinational prefix-XOR decode, width-limited to W.
    assign b = W'(gray2bin(MAX_W'(g), W));

endmodule

// File: rtl/gray_count_checker.sv
// rtl/gray_count_checker.sv - Gray word decoder with +1 sequence check, lock and saturating error count
module gray_count_checker
    import gray_pkg::*;
#(
    parameter int W      = 32,
    parameter int LOCK_N = 4,
    parameter int ECW    = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   g,
    input  logic           g_valid,
    output logic [W-1:0]   bin,
    output logic           bin_valid,
    output logic           step_err,
    output logic           lock,
    output logic [ECW-1:0] err_count
);

    localparam int GW = $clog2(LOCK_N + 1);

    logic [W-1:0]  s1_g;
    logic          s1_valid;
    logic [W-1:0]  dec;
    logic [W-1:0]  prev;
    logic          correct;
    chk_state_t    state;
    chk_state_t    state_d;
    logic [GW-1:0] good;
    logic [GW-1:0] good_d;
    logic [GW-1:0] good_inc;
    logic          err_d;

    // Stage 1: capture the raw Gray word; the valid bit only lives for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_g     <= '0;
            s1_valid <= 1'b0;
        end else if (g_valid) begin
            s1_g     <= g;
            s1_valid <= 1'b1;
        end else begin
            s1_valid <= 1'b0;
        end
    end

    gray2bin_w #(.W(W)) u_dec (
        .g (s1_g),
        .b (dec)
    );

    // The wrap from all-ones to zero falls out of the W-bit add.
    assign correct  = (dec == prev + W'(1));
    assign good_inc = good + GW'(1);

    // Next-state logic: only a decoded sample moves the checker; idle cycles hold.
    always_comb begin
        state_d = state;
        good_d  = good;
        err_d   = 1'b0;
        if (s1_valid) begin
            case (state)
                EMPTY: begin
                    state_d = ACQ;
                    good_d  = '0;
                end
                ACQ: begin
                    if (correct) begin
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_N)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        err_d  = 1'b1;
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (!correct) begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = ACQ;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    good_d  = '0;
                end
            endcase
        end
    end

    // FSM state and good-step counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            good  <= '0;
        end else begin
            state <= state_d;
            good  <= good_d;
        end
    end

    // Stage 2 outputs: decoded value, pulse flags, resync point and error tally.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin       <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            prev      <= '0;
            err_count <= '0;
        end else begin
            bin_valid <= s1_valid;
            step_err  <= err_d;
            if (s1_valid) begin
                bin  <= dec;
                prev <= dec;
            end
            if (err_d && (err_count != '1)) begin
                err_count <= err_count + ECW'(1);
            end
        end
    end

    // State is itself a flop, so lock is a registered output.
    assign lock = (state == LOCKED);

endmodule

// File: tb/tb_gray_count_checker.sv
// tb/tb_gray_count_checker.sv - self-checking bench for gray_count_checker
module tb_gray_count_checker;
    import gray_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] g;
    logic        g_valid;
    logic [31:0] bin;
    logic        bin_valid;
    logic        step_err;
    logic        lock;
    logic [15:0] err_count;
    logic [31:0] bin_s;
    logic        bin_valid_s;
    logic        step_err_s;
    logic        lock_s;
    logic [1:0]  err_count_s;

    always #5 clk = ~clk;

    gray_count_checker #(.W(32), .LOCK_N(4), .ECW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .g         (g),
        .g_valid   (g_valid),
        .bin       (bin),
        .bin_valid (bin_valid),
        .step_err  (step_err),
        .lock      (lock),
        .err_count (err_count)
    );

    gray_count_checker #(.W(32), .LOCK_N(4), .ECW(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .g         (g),
        .g_valid   (g_valid),
        .bin       (bin_s),
        .bin_valid (bin_valid_s),
        .step_err  (step_err_s),
        .lock      (lock_s),
        .err_count (err_count_s)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        chk;
        logic        v;
        logic [31:0] bin;
        logic        err;
        logic        lock;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          v;
        logic [31:0] val;
        exp_t        e;
    } vec_t;

    exp_t pipe0 = '0;
    exp_t pipe1 = '0;

    // Reference model state: sequence history as plain numbers.
    bit          m_have;
    logic [31:0] m_prev;
    logic [31:0] m_last;
    int          m_run;
    int          m_cnt;

    function automatic exp_t mk(logic v, logic [31:0] b, logic e, logic l, logic [15:0] c);
        exp_t r;
        r.chk  = 1'b1;
        r.v    = v;
        r.bin  = b;
        r.err  = e;
        r.lock = l;
        r.cnt  = c;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0;
        m_prev = '0;
        m_last = '0;
        m_run  = 0;
        m_cnt  = 0;
    endtask

    // A value is a good step iff it is the previous one plus one (mod 2^32);
    // lock means at least 4 good steps since the first sample or the last error.
    task automatic model_step(input bit v, input logic [31:0] val, output exp_t r);
        logic e;
        logic [31:0] nxt;
        e = 1'b0;
        if (v) begin
            nxt = m_prev + 32'd1;
            if (!m_have) begin
                m_have = 1'b1;
                m_run  = 0;
            end else if (val == nxt) begin
                m_run++;
            end else begin
                e = 1'b1;
                m_run = 0;
                m_cnt++;
            end
            m_prev = val;
            m_last = val;
        end
        r = mk(v, m_last, e, (m_have && m_run >= 4), 16'(m_cnt));
    endtask

    // One cycle at the falling edge: compare the record due now, then drive new inputs.
    task automatic cycle(input bit rst, input bit v, input logic [31:0] val,
                         input bit use_tab, input exp_t tab);
        exp_t m;
        if (pipe1.chk) begin
            check("bin_valid", 64'(bin_valid), 64'(pipe1.v));
            check("bin", 64'(bin), 64'(pipe1.bin));
            check("step_err", 64'(step_err), 64'(pipe1.err));
            check("lock", 64'(lock), 64'(pipe1.lock));
            check("err_count", 64'(err_count), 64'(pipe1.cnt));
            check("sat_err_count", 64'(err_count_s), 64'((pipe1.cnt > 16'd3) ? 16'd3 : pipe1.cnt));
        end
        pipe1 = pipe0;
        if (rst) begin
            model_reset();
            pipe1 = mk(0, 0, 0, 0, 0);
            pipe0 = mk(0, 0, 0, 0, 0);
        end else begin
            model_step(v, val, m);
            pipe0 = use_tab ? tab : m;
        end
        reset   = rst;
        g_valid = v;
        g       = v ? 32'(bin2gray(64'(val), 32)) : $urandom;
        @(negedge clk);
    endtask

    task automatic samp(input logic [31:0] val);
        cycle(1'b0, 1'b1, val, 1'b0, '0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, '0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b0, '0);
    endtask

    vec_t        tab [11];
    logic [31:0] nv;
    int          r;

    initial begin
        reset   = 1'b1;
        g_valid = 1'b0;
        g       = '0;
        model_reset();
        @(negedge clk);

        tab[0]  = '{1'b1, 1'b0, 32'd0, mk(0, 0, 0, 0, 0)};
        tab[1]  = '{1'b0, 1'b1, 32'd0, mk(1, 0, 0, 0, 0)};
        tab[2]  = '{1'b0, 1'b1, 32'd1, mk(1, 1, 0, 0, 0)};
        tab[3]  = '{1'b0, 1'b1, 32'd2, mk(1, 2, 0, 0, 0)};
        tab[4]  = '{1'b0, 1'b1, 32'd3, mk(1, 3, 0, 0, 0)};
        tab[5]  = '{1'b0, 1'b1, 32'd4, mk(1, 4, 0, 1, 0)};
        tab[6]  = '{1'b0, 1'b1, 32'd5, mk(1, 5, 0, 1, 0)};
        tab[7]  = '{1'b0, 1'b0, 32'd0, mk(0, 5, 0, 1, 0)};
        tab[8]  = '{1'b0, 1'b1, 32'd7, mk(1, 7, 1, 0, 1)};
        tab[9]  = '{1'b0, 1'b1, 32'd7, mk(1, 7, 1, 0, 2)};
        tab[10] = '{1'b0, 1'b1, 32'd8, mk(1, 8, 0, 0, 2)};
        for (int i = 0; i < 11; i++) begin
            cycle(tab[i].rst, tab[i].v, tab[i].val, 1'b1, tab[i].e);
        end
        idle();
        idle();

        // Continuous count 0..20 from reset.
        do_reset();
        for (int i = 0; i <= 20; i++) samp(32'(i));
        idle();
        idle();
        check("count_lock", 64'(lock), 64'd1);
        check("count_err_count", 64'(err_count), 64'd0);

        // Wrap through all-ones to zero while locked.
        do_reset();
        for (int i = 0; i < 11; i++) samp(32'hFFFF_FFF8 + 32'(i));
        idle();
        idle();
        check("wrap_lock", 64'(lock), 64'd1);
        check("wrap_err_count", 64'(err_count), 64'd0);

        // Skip from locked, then relock.
        samp(32'd10);
        samp(32'd12);
        for (int i = 13; i <= 16; i++) samp(32'(i));
        idle();
        idle();
        check("skip_err_count", 64'(err_count), 64'd2);
        check("skip_relock", 64'(lock), 64'd1);

        // Gaps between good steps, then a repeat.
        do_reset();
        samp(32'd5);
        idle();
        samp(32'd6);
        idle();
        samp(32'd7);
        idle();
        samp(32'd7);
        idle();
        idle();
        check("repeat_err_count", 64'(err_count), 64'd1);

        // Reset with one sample in stage 1 and one on the input.
        do_reset();
        for (int i = 0; i < 6; i++) samp(32'(i));
        cycle(1'b1, 1'b1, 32'd6, 1'b0, '0);
        check("rst_bin_valid", 64'(bin_valid), 64'd0);
        check("rst_bin", 64'(bin), 64'd0);
        check("rst_lock", 64'(lock), 64'd0);
        idle();
        check("rst_flush_valid", 64'(bin_valid), 64'd0);
        for (int i = 100; i < 106; i++) samp(32'(i));
        idle();
        idle();
        check("restart_err_count", 64'(err_count), 64'd0);
        check("restart_lock", 64'(lock), 64'd1);

        // Saturation of the 2-bit counter.
        do_reset();
        samp(32'd0);
        for (int i = 0; i < 5; i++) samp(32'd0);
        idle();
        idle();
        idle();
        check("sat_hold", 64'(err_count_s), 64'd3);
        check("sat_full_count", 64'(err_count), 64'd5);

        // Randomized mix against the model.
        do_reset();
        nv = $urandom;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 15) begin
                idle();
            end else if (r < 22) begin
                nv = $urandom;
                samp(nv);
            end else if (r < 27) begin
                samp(nv);
            end else begin
                nv = nv + 32'd1;
                samp(nv);
            end
        end
        idle();
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
